mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one N:1 bit-select multiplexor between N requesters. It drives the mux select code and a one-hot grant vector. Each grant is held until the owner signals done, drops its request, or exceeds a maximum hold time. It sits directly in front of the 8:1 select mux; its `sel` output connects straight to the mux select input.

Parameters:
- N, 8, number of requesters; must be a power of two and at least 2.
- SEL_W, 3, select width; equals log2(N).
- MAX_HOLD, 16, maximum consecutive cycles one requester may own the mux; must be at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector, one bit per requester, level-sensitive
- done  input  1  current owner releases the mux; sampled only in GRANT
- grant  output  N  one-hot grant, registered; all-zero when idle
- sel  output  SEL_W  mux select code, registered; index of the granted requester
- sel_valid  output  1  high while a grant is active; downstream gates the mux output with it
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Reset, checked at a clk edge with rst=1:
  - grant=0, sel=0, sel_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, last_ptr=N-1, so the first search starts at index 0.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning last_ptr+1, last_ptr+2, … modulo N.
  - Next edge: grant=onehot(pick), sel=pick, sel_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req to grant is exactly 1 cycle.
- GRANT release conditions, evaluated each cycle in priority order:
  - (a) done=1;
  - (b) req[sel]=0;
  - (c) hold_cnt==MAX_HOLD-1.
  - If none holds, hold_cnt increments and the outputs are unchanged.
- On release:
  - last_ptr<=sel.
  - Re-arbitrate the same cycle over req with bit sel masked off, scan starting at sel+1.
  - If a candidate exists: next edge grants it directly (back-to-back ownership change), hold_cnt=0, stay in GRANT.
  - If no candidate exists: next edge grant=0, sel_valid=0, sel keeps its old value, state=IDLE.
  - The released requester becomes eligible again from IDLE on the following cycle.
- timeout:
  - Pulses high for the one cycle after release due to (c) only.
  - If done=1 and the hold limit occur in the same cycle, done wins and timeout stays 0.
- Grant length: at most MAX_HOLD cycles of sel_valid per ownership.
- hold_cnt width is clog2(MAX_HOLD); it must never wrap, because release at MAX_HOLD-1 prevents it.
- Wrap-around: a scan from index N-1 continues at 0; the pointer arithmetic is modulo N in SEL_W bits.
- Glitch freedom: grant and sel always change on the same edge, and grant==onehot(sel) whenever sel_valid=1.
- Reset mid-grant: the next edge returns to the full reset values regardless of req or done; the in-flight grant is dropped without a timeout pulse.
- done in IDLE: ignored.
- X on req while rst=1: ignored.

Decomposition:
- Shared package `mux_arb_pkg` holds:
  - state enum {IDLE, GRANT};
  - constants ARB_N=8 and ARB_SEL_W=3;
  - function onehot(idx).
- Sub-module `rr_pick`: purely combinational rotating priority finder.
  - Inputs: req[N-1:0], mask_idx, mask_en, start_idx.
  - Outputs: found, idx[SEL_W-1:0].
  - It is instantiated once and shared by the IDLE and release paths.
- The top level holds the FSM, hold counter, pointer, and output registers.

Test Plan:
1. Reset then single request: rst for 2 cycles, then req=8'b0000_0100 → one cycle later grant=8'b0000_0100, sel=2, sel_valid=1. Next, done=1 with req=0 → next cycle grant=0, sel_valid=0, sel=2.
2. Round-robin fairness: req=8'hFF held, done pulsed every 3rd cycle → grant sequence is sel 0,1,2,…,7,0 with each grant lasting 3 cycles, with no IDLE gaps.
3. Timeout with MAX_HOLD=16: req=8'b0001_0000 held, done=0 → sel_valid high exactly 16 cycles. timeout pulses once, then 1 IDLE cycle, then the grant returns to sel=4.
4. Timeout back-to-back: req=8'b1000_0001 with the owner at sel=7 never asserting done → after 16 cycles grant moves to sel=0 on the next edge (wrap) with timeout=1 that cycle.
5. Simultaneous done and limit: assert done on the 16th grant cycle → release occurs, timeout stays 0.
6. Mid-grant reset and request drop: assert rst while grant=8'b0010_0000 → next cycle all outputs are 0. After release, req=8'h21 → grant goes to sel=0 (last_ptr reset to 7).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the FSM state encoding, default sizing and a one-hot encoder.
package mux_arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [ARB_N-1:0] onehot(input logic [ARB_SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set request at or after start_idx,
// optionally ignoring the requester at mask_idx.
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] mask_idx,
    input  logic             mask_en,
    input  logic [SEL_W-1:0] start_idx,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     req_m;
    logic [SEL_W-1:0] cand;

    always_comb begin
        req_m = req;
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        if (mask_en) begin
            req_m[mask_idx] = 1'b0;
        end
        // Candidate index wraps naturally in SEL_W bits, giving the modulo-N scan.
        for (int i = 0; i < N; i++) begin
            cand = start_idx + SEL_W'(i);
            if (!found && req_m[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared N:1 select mux; drives registered sel and one-hot grant.
// state | meaning
// IDLE  | no owner, arbitrate over req starting after last_ptr
// GRANT | sel owns the mux; release on done, dropped req or hold limit
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int SEL_W    = ARB_SEL_W,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  last_ptr_q, last_ptr_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic              timeout_q, timeout_d;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  pick_start;
    logic              in_grant;
    logic              rel_done, rel_drop, rel_hold, release_now;

    assign in_grant   = (state_q == GRANT);
    assign pick_start = in_grant ? (sel_q + SEL_W'(1)) : (last_ptr_q + SEL_W'(1));

    // One finder serves both the idle search and the release-time re-arbitration.
    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req       (req),
        .mask_idx  (sel_q),
        .mask_en   (in_grant),
        .start_idx (pick_start),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    assign rel_done    = done;
    assign rel_drop    = !req[sel_q];
    assign rel_hold    = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign release_now = rel_done || rel_drop || rel_hold;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        last_ptr_d  = last_ptr_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    grant_d     = onehot(pick_idx);
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_ptr_d = sel_q;
                    // Timeout only when the hold limit is the deciding release reason.
                    timeout_d  = !rel_done && !rel_drop && rel_hold;
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = onehot(pick_idx);
                        sel_d   = pick_idx;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        sel_valid_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last_ptr_q  <= SEL_W'(N - 1);
            grant_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_ptr_q  <= last_ptr_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: stimulus queues hand-computed outputs per cycle,
// a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       sel_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];

    mux_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .sel       (sel),
        .sel_valid (sel_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic d,
                        input logic [7:0] eg, input logic [2:0] es,
                        input logic ev, input logic et, input string nm);
        exp_t e;
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.grant = eg;
        e.sel   = es;
        e.valid = ev;
        e.tmo   = et;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({grant, sel, sel_valid, timeout} !== {e.grant, e.sel, e.valid, e.tmo}) begin
                bad++;
                $display("FAIL %s: got grant=%b sel=%0d valid=%b timeout=%b, want grant=%b sel=%0d valid=%b timeout=%b",
                         e.name, grant, sel, sel_valid, timeout, e.grant, e.sel, e.valid, e.tmo);
            end
        end
    end

    initial begin
        logic [2:0] nxt;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        // 1: reset then single request, release with done
        step(1'b1, 8'hxx, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "reset_0");
        step(1'b1, 8'hxx, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "reset_1");
        step(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "single_grant");
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, "single_release");
        step(1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, "single_idle");

        // 2: fairness with all requesting, done every 3rd cycle
        step(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "rr_reset");
        step(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "rr_first");
        for (int k = 0; k < 8; k++) begin
            nxt = 3'(k + 1);
            step(1'b0, 8'hFF, 1'b0, 8'(1 << k), 3'(k), 1'b1, 1'b0, "rr_hold_a");
            step(1'b0, 8'hFF, 1'b0, 8'(1 << k), 3'(k), 1'b1, 1'b0, "rr_hold_b");
            step(1'b0, 8'hFF, 1'b1, 8'(1 << nxt), nxt, 1'b1, 1'b0, "rr_handoff");
        end
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "rr_to_idle");

        // 3: hold-limit timeout, one idle cycle, then regrant
        step(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "to_grant");
        for (int i = 0; i < 15; i++)
            step(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "to_hold");
        step(1'b0, 8'h10, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1, "to_pulse");
        step(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, "to_regrant");
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, "to_release");

        // 4: timeout hands off back-to-back with wrap 7 -> 0
        step(1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "wrap_grant");
        for (int i = 0; i < 15; i++)
            step(1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "wrap_hold");
        step(1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1, "wrap_timeout");
        step(1'b0, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "wrap_done");
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, "wrap_idle");

        // 5: done coinciding with the hold limit suppresses timeout
        step(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "both_grant");
        for (int i = 0; i < 15; i++)
            step(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "both_hold");
        step(1'b0, 8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, "both_release");

        // 6: mid-grant reset, pointer restart, request drop, done in idle
        step(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "mid_grant");
        step(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, "mid_hold");
        step(1'b1, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "mid_reset");
        step(1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "post_reset_ptr");
        step(1'b0, 8'h21, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, "post_done_next");
        step(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "req_drop");
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "drop_idle");
        step(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done_in_idle");

        repeat (2) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
